// File: rtl/risc_toy_pkg.sv
// Shared opcode map, instruction field positions and decoded-control record.
// Imported by the ID/EX decoder and by ALU users.
package risc_toy_pkg;

  // instruction field bit positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RA_HI    = 26;
  localparam int RA_LO    = 22;
  localparam int RB_HI    = 21;
  localparam int RB_LO    = 17;
  localparam int RC_HI    = 16;
  localparam int RC_LO    = 12;
  localparam int I_BIT    = 5;
  localparam int SHAMT_HI = 4;
  localparam int SHAMT_LO = 0;
  localparam int COND_HI  = 2;
  localparam int COND_LO  = 0;
  localparam int IMM17_HI = 16;
  localparam int IMM22_HI = 21;

  // opcode map; ALU control equals the opcode value
  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;
  localparam logic [4:0] OP_LAST = OP_STR;

  // unregistered decode result
  typedef struct packed {
    logic [4:0]  alu_ctrl;
    logic        legal;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic [31:0] imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rc;
    logic        i;
    logic [4:0]  shamt;
    logic [2:0]  cond;
  } dec_t;

  function automatic logic [31:0] sext17(input logic [16:0] v);
    return {{15{v[16]}}, v};
  endfunction

  function automatic logic [31:0] sext22(input logic [21:0] v);
    return {{10{v[21]}}, v};
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: opcode -> control bits, immediate
// selection/sign-extension and raw field extraction.
module id_decode
  import risc_toy_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [4:0]  w_op;
  logic [31:0] w_imm17;
  logic [31:0] w_imm22;

  assign w_op    = i_instr[OPC_HI:OPC_LO];
  assign w_imm17 = sext17(i_instr[IMM17_HI:0]);
  assign w_imm22 = sext22(i_instr[IMM22_HI:0]);

  // opcode decode; fields pass through untouched
  always_comb begin
    o_dec           = '0;
    o_dec.alu_ctrl  = w_op;
    o_dec.legal     = (w_op <= OP_LAST);
    o_dec.ra        = i_instr[RA_HI:RA_LO];
    o_dec.rb        = i_instr[RB_HI:RB_LO];
    o_dec.rc        = i_instr[RC_HI:RC_LO];
    o_dec.i         = i_instr[I_BIT];
    o_dec.shamt     = i_instr[SHAMT_HI:SHAMT_LO];
    o_dec.cond      = i_instr[COND_HI:COND_LO];
    case (w_op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_MOVI: begin
        o_dec.reg_write = 1'b1;
        o_dec.imm       = w_imm17;
      end
      OP_ADD, OP_SUB, OP_NEG, OP_NOT, OP_AND, OP_OR, OP_XOR,
      OP_LSR, OP_ASR, OP_SHL, OP_ROR: begin
        o_dec.reg_write = 1'b1;
      end
      OP_BR: begin
        o_dec.is_branch = 1'b1;
      end
      OP_BRL: begin
        o_dec.is_branch = 1'b1;
        o_dec.reg_write = 1'b1;
      end
      OP_J: begin
        o_dec.is_jump = 1'b1;
        o_dec.imm     = w_imm22;
      end
      OP_JL: begin
        o_dec.is_jump   = 1'b1;
        o_dec.reg_write = 1'b1;
        o_dec.imm       = w_imm22;
      end
      OP_LD: begin
        o_dec.reg_write = 1'b1;
        o_dec.mem_read  = 1'b1;
        o_dec.imm       = w_imm17;
      end
      OP_LDR: begin
        o_dec.reg_write = 1'b1;
        o_dec.mem_read  = 1'b1;
        o_dec.imm       = w_imm22;
      end
      OP_ST: begin
        o_dec.mem_write = 1'b1;
        o_dec.imm       = w_imm17;
      end
      OP_STR: begin
        o_dec.mem_write = 1'b1;
        o_dec.imm       = w_imm22;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_decoder.sv
// ID/EX stage: combinational decode followed by one register stage.
// Edge priority is flush > stall > load; invalid or illegal instructions
// load as bubbles. Optional sticky illegal-opcode flag under macro
// IDEX_ILLEGAL_TRAP_EN (tied low when undefined).
module id_ex_decoder
  import risc_toy_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] instr,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  alu_ctrl,
  output logic        i_out,
  output logic [4:0]  shamt_out,
  output logic [2:0]  cond_out,
  output logic [4:0]  ra_out,
  output logic [4:0]  rb_out,
  output logic [4:0]  rc_out,
  output logic [31:0] imm_out,
  output logic        valid_out,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal_flag
);

  dec_t w_dec;
  dec_t r_ex;
  logic r_valid;
  logic w_load;
  logic w_take;

  id_decode u_dec (
    .i_instr (instr),
    .o_dec   (w_dec)
  );

  assign w_load = !flush && !stall;
  assign w_take = in_valid && w_dec.legal;

  // EX register: flush clears control, stall holds, otherwise load
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ex    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid          <= 1'b0;
      r_ex.reg_write   <= 1'b0;
      r_ex.mem_read    <= 1'b0;
      r_ex.mem_write   <= 1'b0;
      r_ex.is_branch   <= 1'b0;
      r_ex.is_jump     <= 1'b0;
    end else if (!stall) begin
      // data fields always load; control bits only for a real, legal op
      r_ex           <= w_dec;
      r_valid        <= w_take;
      r_ex.reg_write <= w_dec.reg_write & w_take;
      r_ex.mem_read  <= w_dec.mem_read  & w_take;
      r_ex.mem_write <= w_dec.mem_write & w_take;
      r_ex.is_branch <= w_dec.is_branch & w_take;
      r_ex.is_jump   <= w_dec.is_jump   & w_take;
    end
  end

`ifdef IDEX_ILLEGAL_TRAP_EN
  logic r_illegal;

  // sticky trap: set on an accepted illegal opcode, cleared only by reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_illegal <= 1'b0;
    else if (w_load && in_valid && !w_dec.legal)
      r_illegal <= 1'b1;
  end

  assign illegal_flag = r_illegal;
`else
  assign illegal_flag = 1'b0;
`endif

  assign alu_ctrl  = r_ex.alu_ctrl;
  assign i_out     = r_ex.i;
  assign shamt_out = r_ex.shamt;
  assign cond_out  = r_ex.cond;
  assign ra_out    = r_ex.ra;
  assign rb_out    = r_ex.rb;
  assign rc_out    = r_ex.rc;
  assign imm_out   = r_ex.imm;
  assign valid_out = r_valid;
  assign reg_write = r_ex.reg_write;
  assign mem_read  = r_ex.mem_read;
  assign mem_write = r_ex.mem_write;
  assign is_branch = r_ex.is_branch;
  assign is_jump   = r_ex.is_jump;

endmodule

// File: tb/tb_id_ex_decoder.sv
// Directed-vector bench for id_ex_decoder with hand-computed expectations.
module tb_id_ex_decoder;

`ifdef IDEX_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] instr;
  logic        in_valid, stall, flush;
  logic [4:0]  alu_ctrl, shamt_out, ra_out, rb_out, rc_out;
  logic [2:0]  cond_out;
  logic        i_out;
  logic [31:0] imm_out;
  logic        valid_out, reg_write, mem_read, mem_write, is_branch, is_jump;
  logic        illegal_flag;

  int checks = 0;
  int errors = 0;

  id_ex_decoder dut (
    .CLK(CLK), .RSTn(RSTn), .instr(instr), .in_valid(in_valid),
    .stall(stall), .flush(flush), .alu_ctrl(alu_ctrl), .i_out(i_out),
    .shamt_out(shamt_out), .cond_out(cond_out), .ra_out(ra_out),
    .rb_out(rb_out), .rc_out(rc_out), .imm_out(imm_out),
    .valid_out(valid_out), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .is_branch(is_branch), .is_jump(is_jump),
    .illegal_flag(illegal_flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge, then sample 1ns later
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk17(input logic [4:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [16:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [31:0] mk22(input logic [4:0] op, input logic [4:0] ra,
                                       input logic [21:0] imm);
    return {op, ra, imm};
  endfunction

  initial begin
    RSTn = 1'b0; instr = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_alu",   {27'd0, alu_ctrl}, 32'd0);
    chk("rst_imm",   imm_out, 32'd0);
    chk("rst_ill",   {31'd0, illegal_flag}, 32'd0);
    step();
    RSTn = 1'b1;
    step();

    // ADDI, imm17 = 0x1FFFF -> all ones
    instr = mk17(5'd0, 5'd3, 5'd4, 17'h1FFFF); in_valid = 1'b1;
    step();
    chk("addi_alu",   {27'd0, alu_ctrl}, 32'd0);
    chk("addi_imm",   imm_out, 32'hFFFF_FFFF);
    chk("addi_rw",    {31'd0, reg_write}, 32'd1);
    chk("addi_valid", {31'd0, valid_out}, 32'd1);
    chk("addi_ra",    {27'd0, ra_out}, 32'd3);

    // ST, imm17 = 0x10
    instr = mk17(5'd21, 5'd1, 5'd2, 17'h00010);
    step();
    chk("st_mw",  {31'd0, mem_write}, 32'd1);
    chk("st_rw",  {31'd0, reg_write}, 32'd0);
    chk("st_imm", imm_out, 32'h0000_0010);
    chk("st_alu", {27'd0, alu_ctrl}, 32'd21);

    // JL, imm22 = 0x200000 -> sign-extended negative
    instr = mk22(5'd18, 5'd31, 22'h200000);
    step();
    chk("jl_jump", {31'd0, is_jump}, 32'd1);
    chk("jl_rw",   {31'd0, reg_write}, 32'd1);
    chk("jl_imm",  imm_out, 32'hFFE0_0000);
    chk("jl_br",   {31'd0, is_branch}, 32'd0);

    // ADD R-type with raw fields: i=1, shamt=0x16, cond=6, imm=0
    instr = {5'd4, 5'd1, 5'd2, 5'd3, 6'd0, 1'b1, 5'b10110};
    step();
    chk("add_rc",    {27'd0, rc_out}, 32'd3);
    chk("add_rb",    {27'd0, rb_out}, 32'd2);
    chk("add_i",     {31'd0, i_out}, 32'd1);
    chk("add_shamt", {27'd0, shamt_out}, 32'h16);
    chk("add_cond",  {29'd0, cond_out}, 32'd6);
    chk("add_imm",   imm_out, 32'd0);

    // BR: branch only, no write
    instr = mk17(5'd15, 5'd0, 5'd0, 17'h12345);
    step();
    chk("br_br",  {31'd0, is_branch}, 32'd1);
    chk("br_rw",  {31'd0, reg_write}, 32'd0);
    chk("br_imm", imm_out, 32'd0);

    // LDR with positive imm22
    instr = mk22(5'd20, 5'd7, 22'h0ABCDE);
    step();
    chk("ldr_mr",  {31'd0, mem_read}, 32'd1);
    chk("ldr_imm", imm_out, 32'h000A_BCDE);

    // SUB then stall 3 cycles with XOR presented
    instr = {5'd5, 27'd0};
    step();
    chk("sub_alu", {27'd0, alu_ctrl}, 32'd5);
    stall = 1'b1; instr = {5'd10, 27'd0};
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_hold%0d", k), {27'd0, alu_ctrl}, 32'd5);
    end
    stall = 1'b0;
    step();
    chk("xor_alu", {27'd0, alu_ctrl}, 32'd10);

    // LD, then stall+flush together
    instr = mk17(5'd19, 5'd2, 5'd3, 17'h10000);
    step();
    chk("ld_mr",  {31'd0, mem_read}, 32'd1);
    chk("ld_imm", imm_out, 32'hFFFF_0000);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("sf_valid", {31'd0, valid_out}, 32'd0);
    chk("sf_mr",    {31'd0, mem_read}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // in_valid=0 -> bubble
    instr = mk17(5'd0, 5'd1, 5'd1, 17'h1); in_valid = 1'b0;
    step();
    chk("bub_valid", {31'd0, valid_out}, 32'd0);
    chk("bub_rw",    {31'd0, reg_write}, 32'd0);

    // flush alone squashes a valid load
    in_valid = 1'b1; flush = 1'b1; instr = mk22(5'd17, 5'd0, 22'h1);
    step();
    chk("fl_jump", {31'd0, is_jump}, 32'd0);
    flush = 1'b0;

    // illegal opcode 25
    instr = {5'd25, 27'h1234};
    step();
    chk("ill_valid", {31'd0, valid_out}, 32'd0);
    chk("ill_flag",  {31'd0, illegal_flag}, {31'd0, TRAP});
    instr = {5'd4, 27'd0};
    step();
    chk("ill_sticky", {31'd0, illegal_flag}, {31'd0, TRAP});
    chk("post_ill_valid", {31'd0, valid_out}, 32'd1);
    RSTn = 1'b0;
    #1;
    chk("ill_rst", {31'd0, illegal_flag}, 32'd0);
    RSTn = 1'b1;
    step();

    // reset mid-stall discards held instruction
    instr = {5'd6, 27'd0};
    step();
    chk("neg_alu", {27'd0, alu_ctrl}, 32'd6);
    stall = 1'b1;
    step();
    #2 RSTn = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, valid_out}, 32'd0);
    chk("mrst_alu",   {27'd0, alu_ctrl}, 32'd0);
    chk("mrst_rw",    {31'd0, reg_write}, 32'd0);
    step();
    RSTn = 1'b1; stall = 1'b0; instr = {5'd9, 5'd8, 22'd0};
    step();
    chk("rel_alu",   {27'd0, alu_ctrl}, 32'd9);
    chk("rel_valid", {31'd0, valid_out}, 32'd1);
    chk("rel_ra",    {27'd0, ra_out}, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
